// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Glyphs are stored active-low ({g,f,e,d,c,b,a}, bit 0 = a).
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0011000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b0100111;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000100;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // XOR mask turning an active-low segment pattern into the board polarity.
  function automatic logic [6:0] pol_mask(input int active_low);
    if (active_low != 0) begin
      return 7'b0000000;
    end else begin
      return 7'b1111111;
    end
  endfunction

endpackage

// File: rtl/display_mux_n_hex7seg.sv
// Nibble to 7-segment glyph decoder; output is always active-low,
// polarity is applied by the caller.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // glyph lookup
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = GLYPH_A;
      4'hB:    seg = GLYPH_B;
      4'hC:    seg = GLYPH_C;
      4'hD:    seg = GLYPH_D;
      4'hE:    seg = GLYPH_E;
      4'hF:    seg = GLYPH_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_mux_n.sv
// Time-multiplexed DIGITS-digit hex display driver with per-digit dp,
// leading-zero blanking, PWM brightness and frame-aligned double buffering.
module display_mux_n
  import display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIV_W      = 16,
  parameter int BR_W       = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [BR_W-1:0]       bright,
  output logic [6:0]            SSeg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       POL      = pol_mask(ACTIVE_LOW);
  localparam logic             INV      = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]    pre_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] act_num_r;
  logic [DIGITS-1:0]   act_dp_r;
  logic [4*DIGITS-1:0] pend_num_r;
  logic [DIGITS-1:0]   pend_dp_r;
  logic                pending_r;
  logic                frame_done_r;
  logic [6:0]          sseg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   an_r;

  logic                tick_s;
  logic                wrap_s;
  logic [DIGITS-1:0]   lz_mask_s;
  logic                zero_run_s;
  logic [3:0]          nib_s;
  logic [6:0]          glyph_s;
  logic                blank_s;
  logic                duty_s;
  logic [DIGITS-1:0]   an_on_s;

  assign tick_s = &pre_r;
  assign wrap_s = tick_s && (idx_r == LAST_IDX);

  // prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= '0;
      idx_r <= '0;
    end else begin
      pre_r <= pre_r + DIV_W'(1);
      if (wrap_s) begin
        idx_r <= '0;
      end else if (tick_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  // double buffer: a load landing on the wrap bypasses the pending stage
  always_ff @(posedge clk) begin
    if (rst) begin
      act_num_r    <= '0;
      act_dp_r     <= '0;
      pend_num_r   <= '0;
      pend_dp_r    <= '0;
      pending_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (wrap_s) begin
        pending_r <= 1'b0;
        if (load) begin
          act_num_r <= num;
          act_dp_r  <= dp_in;
        end else if (pending_r) begin
          act_num_r <= pend_num_r;
          act_dp_r  <= pend_dp_r;
        end
      end else if (load) begin
        pend_num_r <= num;
        pend_dp_r  <= dp_in;
        pending_r  <= 1'b1;
      end
    end
  end

  // lz_mask_s[i] set when active nibbles i..DIGITS-1 are all zero (i > 0)
  always_comb begin
    lz_mask_s  = '0;
    zero_run_s = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run_s   = zero_run_s & (act_num_r[4*i +: 4] == 4'h0);
      lz_mask_s[i] = zero_run_s;
    end
  end

  assign nib_s   = act_num_r[{idx_r, 2'b00} +: 4];
  assign blank_s = lz_en & lz_mask_s[idx_r];
  assign duty_s  = (pre_r[DIV_W-1 -: BR_W] <= bright);

  // one-hot anode gated by the brightness window
  always_comb begin
    an_on_s = '0;
    if (duty_s) begin
      an_on_s[idx_r] = 1'b1;
    end else begin
      an_on_s = '0;
    end
  end

  hex7seg u_dec (
    .nib (nib_s),
    .seg (glyph_s)
  );

  // registered display outputs in board polarity
  always_ff @(posedge clk) begin
    if (rst) begin
      sseg_r <= SEG_OFF ^ POL;
      dp_r   <= INV;
      an_r   <= {DIGITS{INV}};
    end else begin
      sseg_r <= (blank_s ? SEG_OFF : glyph_s) ^ POL;
      dp_r   <= act_dp_r[idx_r] ^ INV;
      an_r   <= an_on_s ^ {DIGITS{INV}};
    end
  end

  assign SSeg       = sseg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;
  assign pending    = pending_r;

endmodule

// File: doc/display_mux_n.md
Name: display_mux_n

Overview:
- Parametrised time-multiplexed 7-segment driver for DIGITS hex digits with per-digit decimal points, optional leading-zero blanking, PWM brightness, and a tear-free double-buffered value update.
- Sits between the ALU result/debug datapath and the board's common-anode displays.
- Replaces the fixed 4-digit driver.
- Adds registered outputs, a frame-boundary handshake and a synchronous reset.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- DIV_W, 16, prescaler width; each digit slot lasts 2^DIV_W clk cycles.
- BR_W, 3, brightness control width.
- ACTIVE_LOW, 1, 1 = segments/anodes/dp asserted low; 0 = asserted high.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- num  in  4*DIGITS  hex value; nibble i drives digit i (digit 0 rightmost)
- dp_in  in  DIGITS  decimal-point request per digit
- load  in  1  1-cycle strobe; captures num/dp_in into the pending buffer
- lz_en  in  1  leading-zero suppression enable
- bright  in  BR_W  duty level; all-ones = full on
- SSeg  out  7  segments {g,f,e,d,c,b,a}, bit 0 = a
- dp  out  1  decimal point of the active digit
- an  out  DIGITS  digit enables, one-hot per ACTIVE_LOW
- frame_done  out  1  1-cycle pulse when the scan wraps to digit 0
- pending  out  1  high while a loaded value awaits its frame boundary

Behaviour:
- Reset (rst=1 at posedge):
  - pre=0, idx=0, active buffer=0, pending buffer=0, pending=0, frame_done=0.
  - an, SSeg and dp all deasserted (all ones when ACTIVE_LOW=1).
- Prescaler: pre increments every cycle and wraps from 2^DIV_W-1 to 0. tick = (pre == all-ones).
- Digit index: idx advances on tick and wraps from DIGITS-1 to 0. frame_done=1 in the cycle after a tick that wraps idx.
- Load handshake:
  - load=1 copies num/dp_in into the pending buffer and sets pending=1.
  - A repeated load before the boundary overwrites the buffer (last wins).
  - On a wrapping tick with pending=1, the pending buffer is copied to the active buffer and pending clears.
  - If load coincides with a wrapping tick, num/dp_in go straight to the active buffer and pending stays 0.
  - Only the active buffer is ever displayed, so no mid-frame tearing.
- Blanking: digit i is blank when lz_en=1, i>0, and active nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked; value 0 shows a single "0".
  - A blank digit drives all segments off; its dp still follows the active dp bit.
- Decode is hex 0-F with the team glyphs (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000100, F=0001110
  - ACTIVE_LOW=0 inverts all outputs.
- Brightness: the anode for idx is enabled only while pre[DIV_W-1 -: BR_W] <= bright; otherwise all anodes are off. bright=all-ones gives 100% duty. Requires DIV_W >= BR_W.
- Outputs: an, SSeg and dp are registered and update one clk after the idx/pre change that causes them. Exactly one anode at most is ever enabled.
- Reset mid-frame: takes effect on the next posedge and discards both buffers.
- Input stability: lz_en and bright may change at any time and take effect on the next registered output.

Decomposition:
- Shared package (display_pkg):
  - glyph constants for 0-F
  - SEG_OFF constant
  - the function that derives the polarity mask from ACTIVE_LOW
- Sub-module hex7seg: a combinational 4-bit nibble to 7-bit active-low glyph decoder, instantiated once after the digit mux.
- The prescaler, idx counter, buffers and blanking logic stay in display_mux_n.

Test Plan (DIGITS=4, DIV_W=3, BR_W=2, ACTIVE_LOW=1):
- Reset and scan:
  - Stimulus: rst for 2 cycles, then load num=16'h1234.
  - Required: after reset an=1111 and SSeg=1111111. After the first boundary, an cycles 1110→1101→1011→0111 every 8 clk with SSeg glyphs 4,3,2,1. frame_done pulses every 32 clk.
- Tear-free update:
  - Stimulus: load 16'hABCD while idx=2, then check pending.
  - Required: pending=1 and digits still show 1234 until idx wraps. In the frame_done cycle pending=0 and the next frame shows D,C,B,A.
- Simultaneous load and boundary:
  - Stimulus: assert load with num=16'h0F00 exactly on a wrapping tick.
  - Required: pending stays 0 and the next frame shows 0,0,F,0.
- Leading zeros:
  - Stimulus: lz_en=1, num=16'h0050, dp_in=4'b1000.
  - Required: digits 3 and 2 show SSeg=1111111, with digit 3 dp=0 (lit). Digit 1 shows "5", digit 0 shows "0". With num=0, only digit 0 shows "0".
- Brightness:
  - Stimulus: bright=2'b01.
  - Required: within each 8-cycle slot the anode is enabled for 4 cycles (pre[2:1]<=1) and 1111 otherwise. With bright=2'b11 the anode is enabled for all 8 cycles.
- Reset mid-operation:
  - Stimulus: assert rst while pending=1 and idx=3.
  - Required: next cycle an=1111 and pending=0. After release the display shows 0000 until the next load.
